// File: rtl/sa_weight_loader.sv
// Streams a burst of weight words from an upstream valid/ready source into the
// top cell of a systolic column through a small staging FIFO.
module sa_weight_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  out_hold,
  output logic [DATA_WIDTH-1:0] move_buff_out,
  output logic                  move_buff_out_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_acc_cnt;
  logic [LEN_WIDTH-1:0]  r_emit_cnt;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_out;
  logic                  r_out_valid;
  logic                  r_done;

  logic w_full;
  logic w_empty;
  logic w_in_ready;
  logic w_busy;
  logic w_push;
  logic w_pop;
  logic w_last_emit;

  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = in_valid && w_in_ready;
  assign w_pop       = (r_state == LOAD) && !w_empty && !out_hold;
  assign w_last_emit = w_pop && ((r_emit_cnt + LEN_WIDTH'(1)) == r_len);

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && (len != '0)) w_state_next = LOAD;
      end
      LOAD: begin
        w_busy     = 1'b1;
        w_in_ready = !w_full && (r_acc_cnt < r_len);
        if (w_last_emit) w_state_next = DONE;
      end
      DONE: begin
        w_busy       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    // Abort overrides everything, including a burst finishing this cycle.
    if (abort) w_state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_acc_cnt   <= '0;
      r_emit_cnt  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      if (abort) begin
        r_acc_cnt   <= '0;
        r_emit_cnt  <= '0;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= w_pop;
        if (w_pop) begin
          r_out      <= r_mem[r_rd_ptr];
          r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
          r_emit_cnt <= r_emit_cnt + LEN_WIDTH'(1);
        end
        if (w_push) begin
          r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
          r_acc_cnt <= r_acc_cnt + LEN_WIDTH'(1);
        end
        if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
        else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
        if ((r_state == IDLE) && start) begin
          // A zero-length request completes immediately without leaving IDLE.
          if (len == '0) r_done <= 1'b1;
          else           r_len  <= len;
          r_acc_cnt  <= '0;
          r_emit_cnt <= '0;
        end
        if (w_last_emit) r_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !abort && w_push) r_mem[r_wr_ptr] <= in_data;
  end

  assign in_ready            = w_in_ready;
  assign busy                = w_busy;
  assign done                = r_done;
  assign move_buff_out       = r_out;
  assign move_buff_out_valid = r_out_valid;

endmodule

// File: tb/tb_sa_weight_loader.sv
// Directed bench for sa_weight_loader: bursts, backpressure, zero length,
// abort, mid-burst reset and ignored restart.
module tb_sa_weight_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        abort;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        out_hold;
  logic [31:0] move_buff_out;
  logic        move_buff_out_valid;
  logic        busy;
  logic        done;

  sa_weight_loader #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_hold(out_hold), .move_buff_out(move_buff_out),
    .move_buff_out_valid(move_buff_out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          done_cnt = 0;
  logic [31:0] got_q [$];
  int          got_cyc [$];
  logic [31:0] src [16];
  int          acc_cyc0;
  int          idx_at_hold;
  logic        rdy_at_hold;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (move_buff_out_valid) begin
        got_q.push_back(move_buff_out);
        got_cyc.push_back(cyc);
        $display("cycle %0d: word %08h emitted", cyc, move_buff_out);
      end
      if (done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_test();
    got_q.delete();
    got_cyc.delete();
    done_cnt = 0;
    acc_cyc0 = -1;
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    len   = 8'(l);
    tick();
    start = 1'b0;
  endtask

  // Offers src[0..n-1] back to back for a fixed number of cycles, holding the
  // array side for the first hold cycles and re-issuing start at cycle start_at.
  task automatic feed(input int n, input int hold, input int cycles, input int start_at);
    int  idx = 0;
    logic acc;
    for (int c = 0; c < cycles; c++) begin
      in_valid = (idx < n);
      in_data  = (idx < n) ? src[idx] : 32'h0;
      out_hold = (c < hold);
      start    = (c == start_at);
      len      = 8'd3;
      if (hold > 0 && c == hold - 1) begin
        idx_at_hold = idx;
        rdy_at_hold = in_ready;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        if (idx == 0) acc_cyc0 = cyc;
        idx++;
      end
    end
    in_valid = 1'b0;
    out_hold = 1'b0;
    start    = 1'b0;
  endtask

  task automatic check_words(input string tag, input int n);
    check({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      check($sformatf("%s_word%0d", tag, i), got_q[i], src[i]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0;
    in_data = '0; in_valid = 1'b0; out_hold = 1'b0;
    new_test();
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_valid", move_buff_out_valid, 0);
    check("rst_out", move_buff_out, 0);
    rst = 1'b0;
    tick();

    // Basic four-word burst
    new_test();
    src[0] = 32'h3F800000; src[1] = 32'h40000000;
    src[2] = 32'h40400000; src[3] = 32'h40800000;
    do_start(4);
    check("b4_busy", busy, 1);
    check("b4_in_ready", in_ready, 1);
    feed(4, 0, 12, -1);
    check_words("b4", 4);
    if (got_cyc.size() == 4) begin
      check("b4_latency", got_cyc[0] - acc_cyc0, 1);
      check("b4_consecutive", got_cyc[3] - got_cyc[0], 3);
    end
    check("b4_done_cnt", done_cnt, 1);
    check("b4_busy_end", busy, 0);

    // Backpressure: twelve words through an eight-deep FIFO
    new_test();
    for (int i = 0; i < 12; i++) src[i] = 32'hA000_0000 + 32'(i * 17);
    do_start(12);
    feed(12, 10, 40, -1);
    check("bp_accepts_held", idx_at_hold, 8);
    check("bp_ready_full", rdy_at_hold, 0);
    check_words("bp", 12);
    check("bp_done_cnt", done_cnt, 1);

    // Zero length request
    new_test();
    do_start(0);
    check("z_done", done, 1);
    check("z_busy", busy, 0);
    tick();
    check("z_done_clr", done, 0);
    tick(); tick();
    check("z_no_valid", got_q.size(), 0);
    check("z_done_cnt", done_cnt, 1);

    // Abort after three accepts and one emit
    new_test();
    for (int i = 0; i < 6; i++) src[i] = 32'h5500_0000 + 32'(i);
    do_start(6);
    in_valid = 1'b1; in_data = src[0]; out_hold = 1'b1; tick();
    in_data = src[1]; out_hold = 1'b0; tick();
    in_data = src[2]; out_hold = 1'b1; tick();
    check("ab_one_emit", got_q.size(), 1);
    in_data = src[3]; out_hold = 1'b0; abort = 1'b1; tick();
    abort = 1'b0; in_valid = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_valid", move_buff_out_valid, 0);
    check("ab_in_ready", in_ready, 0);
    check("ab_done", done, 0);
    tick(); tick(); tick();
    check("ab_no_done", done_cnt, 0);
    check("ab_no_more", got_q.size(), 1);
    new_test();
    src[0] = 32'hB0B0_0001; src[1] = 32'hB0B0_0002;
    do_start(2);
    feed(2, 0, 8, -1);
    check_words("ab_new", 2);
    check("ab_new_done", done_cnt, 1);

    // Reset with five words staged
    new_test();
    for (int i = 0; i < 5; i++) src[i] = 32'hC000_0000 + 32'(i);
    do_start(8);
    out_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = src[i]; tick();
    end
    in_valid = 1'b0;
    rst = 1'b1; tick();
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_in_ready", in_ready, 0);
    check("mr_valid", move_buff_out_valid, 0);
    check("mr_out", move_buff_out, 0);
    rst = 1'b0; out_hold = 1'b0; tick(); tick();
    check("mr_no_resume", got_q.size(), 0);
    new_test();
    src[0] = 32'hD1; src[1] = 32'hD2; src[2] = 32'hD3;
    do_start(3);
    feed(3, 0, 10, -1);
    check_words("mr_new", 3);
    if (got_cyc.size() == 3) check("mr_latency", got_cyc[0] - acc_cyc0, 1);
    check("mr_done_cnt", done_cnt, 1);

    // Restart attempt while busy
    new_test();
    for (int i = 0; i < 5; i++) src[i] = 32'hE000_0010 + 32'(i);
    do_start(5);
    feed(5, 0, 15, 2);
    check_words("rs", 5);
    check("rs_done_cnt", done_cnt, 1);
    check("rs_busy_end", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
